electro_force_top: RTL and testbench

- Simplified long-range electrostatics engine for the MD pipeline.
- Load phase: streams NUM_PARTICLES 128-bit particle records from the user buffer and deposits each charge into an 8x8x8 periodic charge grid (nearest grid point).
- Query phase: streams NUM_PARTICLES 128-bit position records and returns, per record, the central-difference grid gradient and the local cell charge on the force-DB output bus.

---
 rtl/electro_force_if.sv | 22 ++
 rtl/electro_force_top.sv | 148 ++++++++++++++
 tb/tb_electro_force_top.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/electro_force_if.sv
// Stream bus between the MD pipeline and the electrostatics engine:
// particle/query records in, gradient and cell charge out.
interface electro_force_if;
  logic [1:0]   start_sig;
  logic [127:0] user_buffer_data;
  logic         user_data_available;
  logic [127:0] forcedb_user_buffer_input_data;

  modport master (
    output start_sig,
    output user_buffer_data,
    output user_data_available,
    input  forcedb_user_buffer_input_data
  );

  modport slave (
    input  start_sig,
    input  user_buffer_data,
    input  user_data_available,
    output forcedb_user_buffer_input_data
  );
endinterface

// File: rtl/electro_force_top.sv
// Long-range electrostatics engine: nearest-grid-point charge deposition into a
// periodic 3-D grid, then central-difference gradient lookups per query record.
module electro_force_top #(
  parameter int NUM_PARTICLES = 2048,
  parameter int BEAT_CYCLES   = 4,
  parameter int GRID_BITS     = 3
) (
  input  logic          clk,
  input  logic          rst,
  electro_force_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int CELL_W = 3 * GRID_BITS;
  localparam int CELLS  = 1 << CELL_W;
  localparam int CNT_W  = $clog2(NUM_PARTICLES + 1);
  localparam int PH_W   = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_REC = CNT_W'(NUM_PARTICLES - 1);
  localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(BEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, QUERY, DONE} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [PH_W-1:0]           ph;
  logic                      grid_clr, acc_en, qry_en, ph_rst;
  logic                      sample, run, abort;
  logic signed [DATA_W-1:0]  grid [CELLS];
  logic [4*DATA_W-1:0]       force_p1;

  logic [GRID_BITS-1:0]      ix, iy, iz, ixp, ixm, iyp, iym, izp, izm;
  logic signed [DATA_W-1:0]  q_in;
  logic signed [DATA_W-1:0]  g_c, g_xp, g_xm, g_yp, g_ym, g_zp, g_zm;
  logic                      unused_bits;

  function automatic logic [CELL_W-1:0] cell_at(input logic [GRID_BITS-1:0] x,
                                                input logic [GRID_BITS-1:0] y,
                                                input logic [GRID_BITS-1:0] z);
    return {x, y, z};
  endfunction

  assign run   = bus.start_sig[0];
  assign abort = bus.start_sig[1];
  assign ix    = bus.user_buffer_data[127 -: GRID_BITS];
  assign iy    = bus.user_buffer_data[95 -: GRID_BITS];
  assign iz    = bus.user_buffer_data[63 -: GRID_BITS];
  assign q_in  = bus.user_buffer_data[31:0];
  assign unused_bits = ^{bus.user_buffer_data[127-GRID_BITS:96],
                         bus.user_buffer_data[95-GRID_BITS:64],
                         bus.user_buffer_data[63-GRID_BITS:32]};

  // Neighbour indices wrap naturally at GRID_BITS width (periodic boundaries).
  assign ixp = ix + GRID_BITS'(1);
  assign ixm = ix - GRID_BITS'(1);
  assign iyp = iy + GRID_BITS'(1);
  assign iym = iy - GRID_BITS'(1);
  assign izp = iz + GRID_BITS'(1);
  assign izm = iz - GRID_BITS'(1);

  assign g_c  = grid[cell_at(ix,  iy,  iz )];
  assign g_xp = grid[cell_at(ixp, iy,  iz )];
  assign g_xm = grid[cell_at(ixm, iy,  iz )];
  assign g_yp = grid[cell_at(ix,  iyp, iz )];
  assign g_ym = grid[cell_at(ix,  iym, iz )];
  assign g_zp = grid[cell_at(ix,  iy,  izp)];
  assign g_zm = grid[cell_at(ix,  iy,  izm)];

  assign sample = bus.user_data_available && (ph == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grid_clr  = 1'b0;
    acc_en    = 1'b0;
    qry_en    = 1'b0;
    ph_rst    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      grid_clr  = 1'b1;
      ph_rst    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (run) state_nxt = LOAD;
          else     grid_clr  = 1'b1;
        end
        LOAD: if (sample) begin
          acc_en = 1'b1;
          if (cnt == LAST_REC) begin
            state_nxt = QUERY;
            cnt_nxt   = '0;
            ph_rst    = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        QUERY: if (sample) begin
          qry_en = 1'b1;
          if (cnt == LAST_REC) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        DONE: if (!run) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Beat phase: sample on the first high edge, then once every BEAT_CYCLES edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     ph <= '0;
    else if (ph_rst || !bus.user_data_available) ph <= '0;
    else if (ph == LAST_PH)                       ph <= '0;
    else                                          ph <= ph + PH_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CELLS; i++) grid[i] <= '0;
    end else if (grid_clr) begin
      for (int i = 0; i < CELLS; i++) grid[i] <= '0;
    end else if (acc_en) begin
      grid[cell_at(ix, iy, iz)] <= g_c + q_in;
    end
  end

  // Output stage: one cycle after the query sample, held until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        force_p1 <= '0;
    else if (qry_en) force_p1 <= {g_xp - g_xm, g_yp - g_ym, g_zp - g_zm, g_c};
  end

  assign bus.forcedb_user_buffer_input_data = force_p1;
endmodule

// File: tb/tb_electro_force_top.sv
// Directed bench for electro_force_top: load/query runs with hand-computed
// grid contents, periodic wrap, beat gaps, abort and mid-run reset.
module tb_electro_force_top;
  localparam int N    = 2048;
  localparam int BEAT = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  electro_force_if bus();

  electro_force_top #(
    .NUM_PARTICLES(N),
    .BEAT_CYCLES  (BEAT),
    .GRID_BITS    (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] fx, input logic [31:0] fy,
                           input logic [31:0] fz, input logic [31:0] qc);
    check_val({tag, ".fx"}, bus.forcedb_user_buffer_input_data[127:96], fx);
    check_val({tag, ".fy"}, bus.forcedb_user_buffer_input_data[95:64],  fy);
    check_val({tag, ".fz"}, bus.forcedb_user_buffer_input_data[63:32],  fz);
    check_val({tag, ".qc"}, bus.forcedb_user_buffer_input_data[31:0],   qc);
  endtask

  function automatic logic [127:0] rec(input int cx, input int cy, input int cz,
                                       input logic [31:0] q);
    logic [31:0] x, y, z;
    x = 32'(cx) << 29;
    y = 32'(cy) << 29;
    z = 32'(cz) << 29;
    return {x, y, z, q};
  endfunction

  // One word held for BEAT edges; the last word of a phase drops valid right after its sample.
  task automatic put_word(input logic [127:0] w, input bit last);
    @(negedge clk);
    bus.user_buffer_data    = w;
    bus.user_data_available = 1'b1;
    @(posedge clk);
    if (last) begin
      #1 bus.user_data_available = 1'b0;
      @(posedge clk);
    end else begin
      repeat (BEAT - 1) @(posedge clk);
    end
  endtask

  task automatic query1(input logic [127:0] w);
    @(negedge clk);
    bus.user_buffer_data    = w;
    bus.user_data_available = 1'b1;
    @(posedge clk);
    #1 bus.user_data_available = 1'b0;
  endtask

  task automatic idle_gap();
    @(posedge clk);
    #1;
  endtask

  task automatic go_load();
    @(negedge clk) bus.start_sig = 2'b01;
    @(posedge clk);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                     = 1'b0;
    bus.start_sig           = 2'b00;
    bus.user_buffer_data    = '0;
    bus.user_data_available = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_out("reset", 0, 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_out("post_reset", 0, 0, 0, 0);

    // Run 1: all charge at (1,1,1), with a valid gap and run-enable drop mid-load.
    go_load();
    for (int i = 0; i < N; i++) begin
      if (i == 500)  bus.start_sig = 2'b00;
      if (i == 1500) bus.start_sig = 2'b01;
      put_word(rec(1, 1, 1, 32'd1), i == N - 1);
      if (i == 999) begin
        @(negedge clk) bus.user_data_available = 1'b0;
        repeat (20) @(posedge clk);
      end
    end
    query1(rec(1, 1, 1, 32'd77)); check_out("q111",   0, 0, 0, 32'h800);
    idle_gap();
    query1(rec(2, 1, 1, 32'd0));  check_out("q211",   32'hFFFF_F800, 0, 0, 0);
    idle_gap();
    query1(rec(0, 1, 1, 32'd0));  check_out("q011",   32'h800, 0, 0, 0);
    idle_gap();
    query1(rec(1, 0, 1, 32'd0));  check_out("q101",   0, 32'h800, 0, 0);
    idle_gap();
    query1(rec(1, 1, 2, 32'd0));  check_out("q112",   0, 0, 32'hFFFF_F800, 0);
    idle_gap();

    // Abort in QUERY: output holds, grid cleared.
    @(negedge clk) bus.start_sig = 2'b11;
    @(posedge clk);
    #1 check_out("abort_hold", 0, 0, 32'hFFFF_F800, 0);
    @(negedge clk) bus.start_sig = 2'b00;
    repeat (2) @(posedge clk);

    // Run 2: single q=5 at (0,0,0), rest q=0 elsewhere.
    go_load();
    for (int i = 0; i < N; i++) begin
      if (i == 10)  bus.start_sig = 2'b00;
      if (i == 200) bus.start_sig = 2'b01;
      put_word((i == 0) ? rec(0, 0, 0, 32'd5) : rec(4, 4, 4, 32'd0), i == N - 1);
    end
    @(negedge clk);
    bus.user_buffer_data    = rec(1, 1, 1, 32'd0);
    bus.user_data_available = 1'b1;
    check_out("pre_sample", 0, 0, 32'hFFFF_F800, 0);
    @(posedge clk);
    #1 bus.user_data_available = 1'b0;
    check_out("q111_cleared", 0, 0, 0, 0);
    idle_gap();
    query1(rec(7, 0, 0, 32'd0)); check_out("q700_wrap", 32'd5, 0, 0, 0);
    idle_gap();
    query1(rec(1, 0, 0, 32'd0)); check_out("q100",      32'hFFFF_FFFB, 0, 0, 0);
    idle_gap();
    query1(rec(0, 0, 0, 32'd0)); check_out("q000",      0, 0, 0, 32'd5);
    idle_gap();
    query1(rec(0, 1, 0, 32'd0)); check_out("q010",      0, 32'hFFFF_FFFB, 0, 0);
    idle_gap();
    query1(rec(0, 0, 7, 32'd0)); check_out("q007_wrap", 0, 0, 32'd5, 0);
    idle_gap();
    for (int i = 0; i < N - 6; i++) begin
      put_word({32'(i), 32'(i), 32'(i), 32'd0}, i == N - 7);
    end
    check_out("q_iii_last", 0, 0, 0, 32'd5);
    query1(rec(7, 0, 0, 32'd0)); check_out("done_hold", 0, 0, 0, 32'd5);
    idle_gap();

    // Run 3: async reset mid-load, then a clean q=0 load and query.
    @(negedge clk) bus.start_sig = 2'b00;
    repeat (2) @(posedge clk);
    go_load();
    for (int i = 0; i < 5; i++) put_word(rec(0, 0, 0, 32'd7), 1'b0);
    #2;
    rst                     = 1'b0;
    bus.user_data_available = 1'b0;
    bus.start_sig           = 2'b00;
    #1 check_out("async_reset", 0, 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    go_load();
    for (int i = 0; i < N; i++) put_word(rec(0, 0, 0, 32'd0), i == N - 1);
    query1(rec(0, 0, 0, 32'd0)); check_out("rst_q000", 0, 0, 0, 0);
    idle_gap();
    query1(rec(7, 0, 0, 32'd0)); check_out("rst_q700", 0, 0, 0, 0);
    idle_gap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
